// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants and state types.
package fpu_pkg;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;

  typedef enum logic [1:0] {IDLE, DIV, DONE} fdiv_state_t;

  // Special-case class latched at accept; overrides the computed quotient.
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_DBZ} fdiv_special_t;
endpackage

// File: rtl/fround.sv
// Round-to-nearest-even on a normalised mantissa; carry-out bumps the exponent.
module fround
  import fpu_pkg::*;
(
  input  logic               [MAN_W:0]   i_man,
  input  logic                           i_guard,
  input  logic                           i_sticky,
  input  logic signed        [9:0]       i_exp,
  output logic               [MAN_W-1:0] o_man,
  output logic signed        [9:0]       o_exp
);
  logic             w_inc;
  logic [MAN_W+1:0] w_sum;

  always_comb begin
    w_inc = i_guard & (i_sticky | i_man[0]);
    w_sum = {1'b0, i_man} + {{(MAN_W + 1){1'b0}}, w_inc};
    if (w_sum[MAN_W+1]) begin
      o_man = '0;
      o_exp = i_exp + 10'sd1;
    end else begin
      o_man = w_sum[MAN_W-1:0];
      o_exp = i_exp;
    end
  end
endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single divider: restoring division, one quotient bit per cycle.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int unsigned ITER = 26
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s,
  input  logic [31:0] t,
  input  logic        valid_in,
  output logic        ready,
  output logic [31:0] d,
  output logic        valid_out,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned Q_W   = MAN_W + 3;
  localparam logic signed [9:0] E_BIAS = 10'(BIAS);
  localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);

  fdiv_state_t          r_state;
  fdiv_special_t        r_special;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sign;
  logic signed [9:0]    r_exp;
  logic [MAN_W+1:0]     r_rem;
  logic [MAN_W:0]       r_div;
  logic [Q_W-1:0]       r_q;

  logic                 w_ge;
  logic [MAN_W:0]       w_rem_sub;
  logic [MAN_W:0]       w_man;
  logic                 w_guard;
  logic                 w_sticky;
  logic signed [9:0]    w_exp;
  logic [MAN_W-1:0]     w_fman;
  logic signed [9:0]    w_fexp;

  assign ready = (r_state == IDLE);

  // rem < 2*div always holds, so the difference fits in MAN_W+1 bits.
  always_comb begin
    w_ge      = (r_rem >= {1'b0, r_div});
    w_rem_sub = w_ge ? (r_rem[MAN_W:0] - r_div) : r_rem[MAN_W:0];
  end

  always_comb begin
    if (r_q[Q_W-1]) begin
      w_man    = r_q[Q_W-1:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (r_rem != '0);
      w_exp    = r_exp;
    end else begin
      w_man    = r_q[Q_W-2:1];
      w_guard  = r_q[0];
      w_sticky = (r_rem != '0);
      w_exp    = r_exp - 10'sd1;
    end
  end

  fround u_fround (
    .i_man    (w_man),
    .i_guard  (w_guard),
    .i_sticky (w_sticky),
    .i_exp    (w_exp),
    .o_man    (w_fman),
    .o_exp    (w_fexp)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_special   <= SP_NONE;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      d           <= '0;
      valid_out   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_sign <= s[31] ^ t[31];
            r_exp  <= $signed({2'b00, s[30:23]}) - $signed({2'b00, t[30:23]}) + E_BIAS;
            r_rem  <= {2'b01, s[MAN_W-1:0]};
            r_div  <= {1'b1, t[MAN_W-1:0]};
            r_q    <= '0;
            r_cnt  <= '0;
            if (t[30:23] == '0)      r_special <= SP_DBZ;
            else if (s[30:23] == '0) r_special <= SP_ZERO;
            else                     r_special <= SP_NONE;
            r_state <= DIV;
          end
        end
        DIV: begin
          r_q   <= {r_q[Q_W-2:0], w_ge};
          r_rem <= {w_rem_sub, 1'b0};
          if (r_cnt == CNT_W'(ITER - 1)) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          valid_out   <= 1'b1;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
          if (r_special == SP_DBZ) begin
            d           <= {r_sign, 8'hFF, {MAN_W{1'b0}}};
            div_by_zero <= 1'b1;
          end else if (r_special == SP_ZERO) begin
            d <= {r_sign, 31'b0};
          end else if (w_fexp >= E_MAX) begin
            d        <= {r_sign, 8'hFF, {MAN_W{1'b0}}};
            overflow <= 1'b1;
          end else if (w_fexp <= 10'sd0) begin
            d         <= {r_sign, 31'b0};
            underflow <= 1'b1;
          end else begin
            d <= {r_sign, w_fexp[EXP_W-1:0], w_fman};
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: hand-computed quotients, latency, streaming and reset abort.
module tb_fdiv_seq;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s, t, d;
  logic        valid_in, ready, valid_out, overflow, underflow, div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  fdiv_seq #(.ITER(26)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s           (s),
    .t           (t),
    .valid_in    (valid_in),
    .ready       (ready),
    .d           (d),
    .valid_out   (valid_out),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // ef = {overflow, underflow, div_by_zero}
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic [2:0] ef);
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, ".ready"}, {31'b0, ready}, 32'd1);
    s = a; t = b; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    s = ~a; t = ~b;
    check({tag, ".busy"}, {31'b0, ready}, 32'd0);
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); lat++;
      #1;
      if (lat == 5) valid_in = 1'b1;
      if (lat == 6) valid_in = 1'b0;
      if (valid_out) seen = 1;
    end
    check({tag, ".lat"}, lat, 32'd27);
    check({tag, ".d"}, d, ed);
    check({tag, ".flags"}, {29'b0, overflow, underflow, div_by_zero}, {29'b0, ef});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    int nready, npulse, last, cnt;
    rstn = 1'b1; valid_in = 1'b0; s = '0; t = '0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, ready}, 32'd1);
    check("rst.d", d, 32'd0);
    check("rst.vout_flags", {28'b0, valid_out, overflow, underflow, div_by_zero}, 32'd0);
    @(negedge clk) rstn = 1'b1;

    do_div("6div2",   32'h40C00000, 32'h40000000, 32'h40400000, 3'b000);
    do_div("1div3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000);
    repeat (5) @(posedge clk);
    #1 check("hold.d", d, 32'h3EAAAAAB);
    do_div("m1div0",  32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001);
    do_div("0div5",   32'h00000000, 32'h40A00000, 32'h00000000, 3'b000);
    do_div("ovf",     32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100);
    do_div("unf",     32'h00800000, 32'h7F000000, 32'h00000000, 3'b010);
    do_div("m6div2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000);
    do_div("1div1",   32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
    do_div("e255",    32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b100);
    do_div("exp0",    32'h00800000, 32'h40000000, 32'h00000000, 3'b010);
    do_div("exp1",    32'h00800000, 32'h3F800000, 32'h00800000, 3'b000);
    do_div("exp254",  32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000);
    do_div("0div0",   32'h00000000, 32'h00000000, 32'h7F800000, 3'b001);

    // valid_in held high: one accept every 28 cycles
    @(negedge clk);
    s = 32'h40C00000; t = 32'h40000000; valid_in = 1'b1;
    nready = 0; npulse = 0; last = -1;
    for (int i = 0; i < 85; i++) begin
      if (i > 0) @(negedge clk);
      if (ready) nready++;
      if (valid_out) begin
        npulse++;
        check("stream.d", d, 32'h40400000);
        if (last >= 0) check("stream.gap", i - last, 32'd28);
        last = i;
      end
    end
    valid_in = 1'b0;
    check("stream.ready_cycles", nready, 32'd4);
    check("stream.pulses", npulse, 32'd3);

    // reset in the middle of DIV
    @(negedge clk);
    s = 32'h3F800000; t = 32'h40400000; valid_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort.ready", {31'b0, ready}, 32'd1);
    check("abort.d", d, 32'd0);
    check("abort.vout_flags", {28'b0, valid_out, overflow, underflow, div_by_zero}, 32'd0);
    @(negedge clk) rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_out) cnt++;
    end
    check("abort.no_vout", cnt, 32'd0);
    do_div("post_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 The module SHALL have parameter ITER, default 26, giving the number of quotient bits produced by the divider loop, one per cycle.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The module SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port s, input, 32 bits: IEEE-754 single dividend.
REQ-005 The module SHALL have port t, input, 32 bits: IEEE-754 single divisor.
REQ-006 The module SHALL have port valid_in, input, 1 bit: the operand pair s/t is valid this cycle.
REQ-007 The module SHALL have port ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-008 The module SHALL have port d, output, 32 bits: quotient, {sign, exponent[7:0], mantissa[22:0]}.
REQ-009 The module SHALL have port valid_out, output, 1 bit: a one-cycle pulse marking that d and the flags are new.
REQ-010 The module SHALL have ports overflow, underflow and div_by_zero, output, 1 bit each: status for the current d.

Function
REQ-011 The state machine SHALL have states IDLE, DIV and DONE; ready SHALL be 1 only in IDLE.
REQ-012 An operand pair SHALL be accepted on the edge where valid_in=1 and ready=1; s and t SHALL be captured, and the FSM SHALL go to DIV with the iteration counter at 0.
REQ-013 valid_in while not ready SHALL be ignored; captured operands SHALL NOT change until the next accept.
REQ-014 Sign SHALL be s[31] XOR t[31].
REQ-015 Exponent: e_raw = {2'b0,es} - {2'b0,et} + 127, evaluated as a signed 10-bit value.
REQ-016 DIV SHALL run restoring division on {1,ms} by {1,mt}, one quotient bit per cycle.
- Remainder initialised to {1,ms} at accept.
- Each cycle: if rem >= div, then q_bit=1 and rem -= div; rem is then shifted left by 1.
REQ-017 DIV SHALL take exactly ITER cycles, after which the FSM goes to DONE; the counter SHALL wrap to 0.
REQ-018 In DONE, q[25]=1 SHALL select:
- mantissa = q[24:2], guard = q[1], sticky = q[0] | (rem != 0);
- exponent = e_raw.
REQ-019 In DONE, q[25]=0 SHALL select:
- mantissa = q[23:1], guard = q[0], sticky = (rem != 0);
- exponent = e_raw - 1.
REQ-020 Rounding SHALL be round-to-nearest-even: increment when guard & (sticky | mantissa LSB); a carry out of the mantissa SHALL zero the mantissa and increment the exponent.
REQ-021 Final exponent >= 255 SHALL give d = {sign, 8'hFF, 23'b0} with overflow=1.
REQ-022 Final exponent <= 0 SHALL give d = {sign, 31'b0} with underflow=1; no denormals are produced.
REQ-023 Specials SHALL be decided at accept and override the result in REQ-018..REQ-022:
- et == 0: d = {sign, 8'hFF, 23'b0}, div_by_zero=1 (this rule takes precedence).
- Otherwise es == 0: d = {sign, 31'b0} and all flags are 0.
- Inputs with exponent 255 are treated as ordinary numbers.
REQ-024 In DONE, d and the flags SHALL be registered, valid_out SHALL be 1 for exactly one cycle, and the FSM SHALL go to IDLE.
REQ-025 d and the flags SHALL hold until the next DONE.
REQ-026 Latency SHALL be ITER+1 cycles from the accept edge to the valid_out cycle; throughput SHALL be one operation per ITER+2 cycles.
REQ-027 A new accept SHALL be possible in the cycle after valid_out.

Reset
REQ-028 rstn=0 SHALL immediately force state IDLE, counter 0, d=0, valid_out=0, overflow=0, underflow=0 and div_by_zero=0, with ready=1 after the release.
REQ-029 Reset during DIV or DONE SHALL abandon the operation, with no valid_out for it.

Structure
REQ-030 The package fpu_pkg SHALL hold BIAS=127, EXP_MAX=255, the fdiv state enum, and the field widths (EXP_W=8, MAN_W=23).
REQ-031 The round/normalise logic SHALL be the sub-module fround (24-bit mantissa, guard, sticky and exponent in; rounded mantissa and exponent out), reusable by other FPU units.

Verification
REQ-032 s=0x40C00000 (6.0), t=0x40000000 (2.0) -> d=0x40400000 at valid_out, 27 cycles after the accept, with all flags 0.
REQ-033 s=0x3F800000, t=0x40400000 -> d=0x3EAAAAAB, which checks RNE and the q[25]=0 path.
REQ-034 s=0xBF800000, t=0x00000000 -> d=0xFF800000 with div_by_zero=1; s=0x00000000, t=0x40A00000 -> d=0x00000000.
REQ-035 s=0x7F000000, t=0x00800000 -> d=0x7F800000 with overflow=1; s=0x00800000, t=0x7F000000 -> d=0x00000000 with underflow=1.
REQ-036 Hold valid_in=1 continuously -> exactly one accept per ITER+2 cycles, ready=0 throughout DIV and DONE, and no dropped or duplicated results.
REQ-037 Assert rstn=0 at DIV cycle 10, then release -> no valid_out, ready=1, and the next division is correct.
